pipe_stage_reg: RTL and testbench
=================================

// Module: pipe_stage_reg
// PURPOSE
//  Parametrised pipeline stage register for the pipelined CPU (IF/ID, ID/EX, EX/MEM, MEM/WB).
//  Carries one opaque payload (e.g. {PC,instruction}) with a valid bit and supports stall (hold) and flush (bubble).
//  Adds ready/valid handshaking, an optional 1-entry skid buffer and saturating stall/flush event counters.
//  Sits between two pipeline stages; the hazard unit drives stall/flush.
// PARAMETERS
//  DATA_W   64  payload width in bits
//  NOP_VAL  0   payload value presented while out_valid=0 (bubble pattern); DATA_W bits
//  SKID     1   1 = skid buffer present, in_ready registered; 0 = no skid, in_ready combinational
//  CNT_W    16  width of the stall_cnt and flush_cnt event counters
// PORTS
//  clk        in   1       rising-edge clock
//  rst        in   1       asynchronous reset, active-high
//  in_valid   in   1       upstream payload valid
//  in_data    in   DATA_W  upstream payload
//  in_ready   out  1       stage can accept in_data this cycle
//  stall      in   1       hazard unit: freeze the main register
//  flush      in   1       hazard unit: kill all held and incoming payloads
//  out_valid  out  1       main register holds a live payload
//  out_data   out  DATA_W  main register payload (NOP_VAL when out_valid=0)
//  out_ready  in   1       downstream consumes out_data this cycle
//  stall_cnt  out  CNT_W   saturating count of stalled cycles with live payload
//  flush_cnt  out  CNT_W   saturating count of flushes that killed a live payload
// BEHAVIOUR
//  - State: main reg M (out_valid, out_data); skid reg S (s_valid, s_data), present only when SKID=1.
//  - Reset (async, rst=1): out_valid=0, out_data=NOP_VAL, s_valid=0, s_data=NOP_VAL, counters=0.
//    SKID=1: in_ready=1 during reset. SKID=0: in_ready follows the combinational rule below.
//  - accept = in_valid & in_ready. advance = out_valid & out_ready & ~stall.
//  - Priority each edge: rst > flush > stall > normal.
//  - flush=1: out_valid<=0, out_data<=NOP_VAL, s_valid<=0.
//    An input accepted in the flush cycle is discarded. flush wins over a simultaneous stall.
//  - stall=1 (no flush): M holds, even when out_valid=0.
//    SKID=1: if S is empty and accept, S<=in_data and s_valid<=1. SKID=0: in_ready=0.
//  - normal (no flush or stall), M is free when ~out_valid | out_ready:
//    * M free & s_valid: M<=S. S<=in_data if accept, else s_valid<=0.
//    * M free & ~s_valid: M<=in_data if accept, else out_valid<=0 and out_data<=NOP_VAL.
//    * M busy (out_valid & ~out_ready): M holds; accept goes to S.
//  - in_ready:
//    SKID=1: ~s_valid (a registered value; it never depends on out_ready or stall in the same cycle).
//    SKID=0: ~stall & (~out_valid | out_ready).
//  - Latency: 1 cycle input->out_valid when empty and unstalled. Throughput 1 payload per cycle.
//  - Ordering: payloads leave in arrival order. No payload is duplicated.
//    Without a flush, no accepted payload is lost.
//  - stall_cnt: +1 on each edge with stall & out_valid. Saturates at 2^CNT_W-1.
//  - flush_cnt: +1 on each edge with flush & (out_valid | s_valid | accept). Saturates at 2^CNT_W-1.
//  - Counters clear only on rst.
// TESTING
//  1. Stream: DATA_W=64, 4 payloads A..D, one per cycle, out_ready=1.
//     -> out_data = A..D on cycles 1..4; out_valid=1 on those cycles, then 0 with out_data=0.
//  2. Stall: 3 cycles of stall after A is in M, B arriving.
//     -> A held 3 cycles; B captured in S; in_ready=0; stall_cnt=3. Release -> B then C with no loss.
//  3. Flush: A in M, B in S, C presented, flush=1 (with stall=1).
//     -> next cycle out_valid=0, s_valid=0, out_data=NOP_VAL, flush_cnt=1. C not delivered.
//  4. Backpressure: out_ready=0 for 5 cycles with continuous input.
//     -> exactly 2 payloads held, in_ready=0 after 2 accepts, order preserved on release.
//  5. Reset mid-flight: rst=1 asynchronously with M, S full.
//     -> immediately out_valid=0, out_data=NOP_VAL, counters=0; resumes cleanly 1 cycle after release.
//  6. SKID=0, CNT_W=2: 5 stall cycles with live payload.
//     -> in_ready=0 throughout; stall_cnt saturates at 3.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with ready/valid handshake, optional 1-entry skid
// buffer, stall/flush control from the hazard unit and saturating event counters.
module pipe_stage_reg #(
  parameter int                DATA_W  = 64,
  parameter logic [DATA_W-1:0] NOP_VAL = '0,
  parameter bit                SKID    = 1'b1,
  parameter int                CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              stall,
  input  logic              flush,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              accept;
  logic              m_free;

  assign accept = in_valid & in_ready;
  assign m_free = ~out_valid | out_ready;

  generate
    if (SKID) begin : g_skid
      // in_ready comes straight from the skid flop, so upstream never sees
      // a combinational path from out_ready or stall.
      assign in_ready = ~s_valid;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s_valid <= 1'b0;
          s_data  <= NOP_VAL;
        end else if (flush) begin
          s_valid <= 1'b0;
        end else if (stall) begin
          if (~s_valid & accept) begin
            s_valid <= 1'b1;
            s_data  <= in_data;
          end
        end else if (m_free) begin
          if (s_valid) begin
            if (accept) s_data <= in_data;
            else        s_valid <= 1'b0;
          end
        end else if (accept) begin
          s_valid <= 1'b1;
          s_data  <= in_data;
        end
      end
    end else begin : g_noskid
      assign in_ready = ~stall & m_free;
      assign s_valid  = 1'b0;
      assign s_data   = NOP_VAL;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= NOP_VAL;
    end else if (flush) begin
      out_valid <= 1'b0;
      out_data  <= NOP_VAL;
    end else if (!stall && m_free) begin
      if (s_valid) begin
        out_valid <= 1'b1;
        out_data  <= s_data;
      end else if (accept) begin
        out_valid <= 1'b1;
        out_data  <= in_data;
      end else begin
        out_valid <= 1'b0;
        out_data  <= NOP_VAL;
      end
    end
  end

  // Counters saturate rather than wrap so long runs stay meaningful.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && out_valid && stall_cnt != '1)
        stall_cnt <= stall_cnt + 1'b1;
      if (flush && (out_valid || s_valid || accept) && flush_cnt != '1)
        flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench: a skid-buffered 64-bit stage and a no-skid 8-bit stage with
// 2-bit counters, checked against hand-computed values after each edge.
module tb_pipe_stage_reg;

  logic        clk, rst;
  logic        iv, st, fl, ordy;
  logic [63:0] id;
  logic        ir, ov;
  logic [63:0] od;
  logic [15:0] scnt, fcnt;

  logic        b_iv, b_st, b_fl, b_ordy;
  logic [7:0]  b_id;
  logic        b_ir, b_ov;
  logic [7:0]  b_od;
  logic [1:0]  b_scnt, b_fcnt;

  int total, passed;

  pipe_stage_reg #(.DATA_W(64), .NOP_VAL(64'h0), .SKID(1'b1), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(iv), .in_data(id), .in_ready(ir),
    .stall(st), .flush(fl), .out_valid(ov), .out_data(od), .out_ready(ordy),
    .stall_cnt(scnt), .flush_cnt(fcnt));

  pipe_stage_reg #(.DATA_W(8), .NOP_VAL(8'hA5), .SKID(1'b0), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_iv), .in_data(b_id), .in_ready(b_ir),
    .stall(b_st), .flush(b_fl), .out_valid(b_ov), .out_data(b_od), .out_ready(b_ordy),
    .stall_cnt(b_scnt), .flush_cnt(b_fcnt));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [63:0] pat [4];
    pat[0] = 64'hAAAA_0000_0000_0001;
    pat[1] = 64'hBBBB_0000_0000_0002;
    pat[2] = 64'hCCCC_0000_0000_0003;
    pat[3] = 64'hDDDD_0000_0000_0004;
    total = 0; passed = 0;
    rst = 1'b1; iv = 0; id = '0; st = 0; fl = 0; ordy = 0;
    b_iv = 0; b_id = '0; b_st = 0; b_fl = 0; b_ordy = 0;

    #3;
    chk("rst_valid", ov, 0);
    chk("rst_data", od, 0);
    chk("rst_ready", ir, 1);
    chk("rst_scnt", scnt, 0);
    chk("rst_fcnt", fcnt, 0);
    chk("b_rst_data", b_od, 8'hA5);
    chk("b_rst_ready", b_ir, 1);
    #9;
    rst = 1'b0;

    // 1. streaming, one payload per cycle
    iv = 1; ordy = 1;
    for (int i = 0; i < 4; i++) begin
      id = pat[i];
      tick();
      chk("stream_valid", ov, 1);
      chk("stream_data", od, pat[i]);
    end
    iv = 0;
    tick();
    chk("stream_end_valid", ov, 0);
    chk("stream_end_data", od, 0);

    // 2. stall with B arriving into the skid buffer
    iv = 1; id = pat[0];
    tick();
    chk("stall_a_in_m", od, pat[0]);
    id = pat[1]; st = 1;
    tick();
    chk("stall_hold1", od, pat[0]);
    chk("stall_ready0", ir, 0);
    id = pat[2];
    tick();
    chk("stall_hold2", od, pat[0]);
    tick();
    chk("stall_hold3", od, pat[0]);
    chk("stall_ready0b", ir, 0);
    chk("stall_cnt3", scnt, 3);
    st = 0;
    tick();
    chk("stall_rel_b", od, pat[1]);
    chk("stall_rel_ready", ir, 1);
    tick();
    chk("stall_rel_c", od, pat[2]);
    chk("stall_rel_c_valid", ov, 1);
    iv = 0;
    tick();
    chk("stall_drain", ov, 0);
    chk("stall_cnt_kept", scnt, 3);

    // 3. flush (with stall) kills M, S and the incoming payload
    iv = 1; id = pat[0]; ordy = 1;
    tick();
    id = pat[1]; ordy = 0;
    tick();
    chk("flush_pre_m", od, pat[0]);
    chk("flush_pre_s_full", ir, 0);
    id = pat[2]; fl = 1; st = 1;
    tick();
    chk("flush_valid", ov, 0);
    chk("flush_data", od, 0);
    chk("flush_s_empty", ir, 1);
    chk("flush_cnt1", fcnt, 1);
    chk("flush_scnt4", scnt, 4);
    fl = 0; st = 0; iv = 0; ordy = 1;
    tick();
    chk("flush_c_gone", ov, 0);

    // 4. backpressure for 5 cycles with continuous input
    iv = 1; ordy = 0; id = 64'hE;
    tick();
    chk("bp_e", od, 64'hE);
    id = 64'hF;
    tick();
    chk("bp_ready0", ir, 0);
    id = 64'h10;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hold", od, 64'hE);
      chk("bp_ready_hold", ir, 0);
    end
    ordy = 1;
    tick();
    chk("bp_rel_f", od, 64'hF);
    tick();
    chk("bp_rel_g", od, 64'h10);
    iv = 0;
    tick();
    chk("bp_drain", ov, 0);

    // 5. asynchronous reset with M and S full
    iv = 1; ordy = 0; id = 64'h11;
    tick();
    id = 64'h12;
    tick();
    chk("mid_s_full", ir, 0);
    iv = 0;
    #2;
    rst = 1;
    #1;
    chk("arst_valid", ov, 0);
    chk("arst_data", od, 0);
    chk("arst_scnt", scnt, 0);
    chk("arst_fcnt", fcnt, 0);
    chk("arst_ready", ir, 1);
    #2;
    rst = 0; ordy = 1; iv = 1; id = 64'h13;
    tick();
    chk("arst_resume_valid", ov, 1);
    chk("arst_resume_data", od, 64'h13);
    iv = 0;
    tick();

    // 6. no-skid variant, counter saturation at 3
    b_iv = 1; b_id = 8'h3C; b_ordy = 1;
    tick();
    chk("b_load", b_od, 8'h3C);
    b_st = 1;
    #1;
    chk("b_ready_comb", b_ir, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("b_ready0", b_ir, 0);
      chk("b_hold", b_od, 8'h3C);
      chk("b_scnt", b_scnt, (i < 2) ? i + 1 : 3);
    end
    b_st = 0; b_iv = 0;
    tick();
    chk("b_bubble_valid", b_ov, 0);
    chk("b_bubble_data", b_od, 8'hA5);
    chk("b_scnt_sat", b_scnt, 3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
